// File: rtl/io_display_scheduler.sv
// io_display_scheduler: kcpsm6 port decode into a shadow/active text buffer, 4-digit
// multiplexed 7-seg scan with a 1-cycle deghost gap and optional nibble scrolling.
module io_display_scheduler #(
    parameter int CLK_DIV    = 100000,
    parameter int SCROLL_DIV = 250,
    parameter int NUM_AN     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        port_id,
    input  logic              write_strobe,
    input  logic [7:0]        out_port,
    output logic [0:6]        seg,
    output logic [NUM_AN-1:0] an
);
    localparam int RW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int FW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [2:0] {GAP, DIG0, DIG1, DIG2, DIG3} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   rcnt;
    logic [FW-1:0]   fcnt;
    logic [31:0]     shadow, active;
    logic            scroll_en, blank, live;
    logic [2:0]      off, idx, p;
    logic [1:0]      nxt, dig, dig_n;
    logic [3:0]      nib;
    logic            tick, frame, last, wr, unused;

    assign unused = ^port_id[7:3];
    assign p      = port_id[2:0];
    assign wr     = write_strobe;
    assign tick   = rcnt == RW'(CLK_DIV - 1);
    assign frame  = tick && state == DIG3;
    assign last   = fcnt == FW'(SCROLL_DIV - 1);
    assign dig    = 2'(3'(state) - 3'd1);
    assign idx    = off + {1'b0, nxt};
    assign nib    = active[{idx, 2'b00} +: 4];

    always_comb begin
        state_n = state;
        if (state == GAP)
            state_n = state_t'({1'b0, nxt} + 3'd1);
        else if (tick)
            state_n = GAP;
        dig_n = 2'(3'(state_n) - 3'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DIG0;
            rcnt      <= '0;
            fcnt      <= '0;
            shadow    <= '0;
            active    <= '0;
            scroll_en <= 1'b0;
            blank     <= 1'b0;
            live      <= 1'b0;
            off       <= '0;
            nxt       <= '0;
            an        <= '1;
            seg       <= 7'h7F;
        end else begin
            rcnt  <= tick ? '0 : rcnt + 1'b1;
            state <= state_n;
            // The very first tick after reset enters DIG0 rather than advancing past it
            if (tick && state != GAP) begin
                nxt  <= live ? dig + 2'd1 : 2'd0;
                live <= 1'b1;
            end
            if (wr && p inside {[3'd2:3'd5]})
                shadow[{p - 3'd2, 3'd0} +: 8] <= out_port;
            if (wr && p == 3'd7)
                shadow <= '0;
            if (wr && p == 3'd6) begin
                scroll_en <= out_port[1];
                blank     <= out_port[2];
                if (out_port[0])
                    active <= shadow;
            end
            if (!scroll_en) begin
                off  <= '0;
                fcnt <= '0;
            end else if (frame) begin
                fcnt <= last ? '0 : fcnt + 1'b1;
                off  <= last ? off + 3'd1 : off;
            end
            an <= (blank || !live || state_n == GAP) ? '1 : ~(NUM_AN'(1) << dig_n);
            // Digit data is latched once on slot entry and held for the whole slot
            if (!live || state_n == GAP)
                seg <= 7'h7F;
            else if (state == GAP)
                seg <= HEX[nib];
        end
    end
endmodule
